// File: rtl/led_strip_tx.sv
// Serialises a 24-bit colour word onto a single-wire WS2812-style LED data line.
// Each bit is a high pulse, long for '1' and short for '0'. A low latch gap ends the frame.
module led_strip_tx #(
    parameter int BIT_CYCLES   = 6,
    parameter int T0H_CYCLES   = 2,
    parameter int T1H_CYCLES   = 4,
    parameter int LATCH_CYCLES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] colour,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        led_out,
    output logic [1:0]  state_dbg
);

    localparam int MAX_CYCLES = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);
    localparam logic [CW-1:0] CYC_ONE    = CW'(1);
    localparam logic [4:0]    BITS_LAST  = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BIT   = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [4:0]    bit_cnt, bit_cnt_n;
    logic [23:0]   shift, shift_n;
    logic [CW-1:0] high_len_n;
    logic          led_n;
    logic          done_n;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cyc     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            led_out <= 1'b0;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            busy    <= (state_n != S_IDLE);
            done    <= done_n;
            led_out <= led_n;
        end
    end

    // Outputs are computed from the next-cycle counters so every output is a plain flop.
    always_comb begin
        state_n    = state;
        cyc_n      = cyc;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        high_len_n = T0H;
        led_n      = 1'b0;
        done_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (send) begin
                    state_n   = S_BIT;
                    shift_n   = colour;
                    cyc_n     = '0;
                    bit_cnt_n = '0;
                end
            end
            S_BIT: begin
                if (cyc == BIT_LAST) begin
                    cyc_n   = '0;
                    shift_n = {shift[22:0], 1'b0};
                    if (bit_cnt == BITS_LAST) begin
                        state_n   = S_LATCH;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end else begin
                    cyc_n = cyc + CYC_ONE;
                end
            end
            S_LATCH: begin
                if (cyc == LATCH_LAST) begin
                    state_n = S_IDLE;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc + CYC_ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        high_len_n = shift_n[23] ? T1H : T0H;
        led_n      = (state_n == S_BIT) && (cyc_n < high_len_n);
        done_n     = (state == S_LATCH) && (state_n == S_IDLE);
    end

endmodule
